// File: rtl/rot_mul_store.sv
// Rotate-then-multiply engine: rotr(num, ROT) * key via a WIDTH-step shift-add
// multiplier, with results stored in a small valid-tagged memory.
module rot_mul_store #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ROT   = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     num,
    input  logic [WIDTH-1:0]     key,
    input  logic [AW-1:0]        wr_addr,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*WIDTH-1:0]   rd_data
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    addr_q;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    product_q;
    logic [PW-1:0]    rd_data_q;
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    mem [DEPTH];

    logic [WIDTH-1:0] num_rot_c;
    logic [WIDTH:0]   sum_d;
    logic [PW-1:0]    result_c;
    logic             wr_en_c;

    // ROT=0 shifts left by WIDTH, which vanishes in a WIDTH-bit result.
    assign num_rot_c = (num >> ROT) | (num << (WIDTH - ROT));

    // One shift-add step: conditional add into the upper half, carry kept in bit WIDTH.
    assign sum_d    = {1'b0, acc_q} + ({1'b0, mcand_q} & {(WIDTH + 1){mplier_q[0]}});
    assign result_c = {acc_q, mplier_q};
    assign wr_en_c  = (state_q == WRITE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            valid_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= num_rot_c;
                        mplier_q <= key;
                        acc_q    <= '0;
                        count_q  <= CW'(WIDTH);
                        addr_q   <= wr_addr;
                        busy_q   <= 1'b1;
                        state_q  <= MULT;
                    end
                end
                MULT: begin
                    acc_q    <= sum_d[WIDTH:1];
                    mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
                    count_q  <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    valid_q[addr_q] <= 1'b1;
                    product_q       <= result_c;
                    done_q          <= 1'b1;
                    busy_q          <= 1'b0;
                    state_q         <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Data array carries no reset; validity is tracked separately.
    always_ff @(posedge clock) begin
        if (resetn && wr_en_c) begin
            mem[addr_q] <= result_c;
        end
    end

    // Registered read, write-first on an address collision.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_data_q <= '0;
        end else if (wr_en_c && (rd_addr == addr_q)) begin
            rd_data_q <= result_c;
        end else if (valid_q[rd_addr]) begin
            rd_data_q <= mem[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_rot_mul_store.sv
// Directed bench for rot_mul_store: default 4-bit instance plus an 8-bit, ROT=3 instance.
module tb_rot_mul_store;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn;
    logic       start;
    logic [3:0] num, key, wr_addr, rd_addr;
    logic       busy, done;
    logic [7:0] product, rd_data;

    logic        start8;
    logic [7:0]  num8, key8;
    logic [3:0]  wa8, ra8;
    logic        busy8, done8;
    logic [15:0] product8, rd_data8;

    int total = 0;
    int bad   = 0;
    int n;
    int ndone;

    logic [3:0] bn [3] = '{4'h9, 4'hC, 4'hB};
    logic [3:0] bk [3] = '{4'h8, 4'hA, 4'hE};
    logic [3:0] ba [3] = '{4'h1, 4'h2, 4'h3};
    logic [7:0] be [3] = '{8'h30, 8'h1E, 8'hC4};

    rot_mul_store u_dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .num     (num),
        .key     (key),
        .wr_addr (wr_addr),
        .busy    (busy),
        .done    (done),
        .product (product),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    rot_mul_store #(.WIDTH(8), .DEPTH(16), .ROT(3)) u_dut8 (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start8),
        .num     (num8),
        .key     (key8),
        .wr_addr (wa8),
        .busy    (busy8),
        .done    (done8),
        .product (product8),
        .rd_addr (ra8),
        .rd_data (rd_data8)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks until done (bounded); returns the number of edges taken.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (done !== 1'b1 && cnt < 30);
    endtask

    task automatic wait_done8(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (done8 !== 1'b1 && cnt < 40);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; num = '0; key = '0; wr_addr = '0; rd_addr = '0;
        start8 = 1'b0; num8 = '0; key8 = '0; wa8 = '0; ra8 = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_product", 32'(product), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);

        // Default case, accepted on the first edge after reset release; operands then scrambled
        resetn = 1'b1; start = 1'b1; num = 4'h8; key = 4'h8; wr_addr = 4'h8;
        tick();
        chk("dflt_busy", 32'(busy), 32'h1);
        start = 1'b0; num = 4'hF; key = 4'hF; wr_addr = 4'h0;
        wait_done(n);
        chk("dflt_latency", 32'(n), 32'd5);
        chk("dflt_product", 32'(product), 32'h10);
        chk("dflt_busy_at_done", 32'(busy), 32'h0);
        tick();
        chk("dflt_done_pulse", 32'(done), 32'h0);
        rd_addr = 4'h8;
        tick();
        chk("dflt_read8", 32'(rd_data), 32'h10);
        rd_addr = 4'h0;
        tick();
        chk("dflt_read_unwritten", 32'(rd_data), 32'h0);

        // Back-to-back: next start issued in the done cycle
        num = bn[0]; key = bk[0]; wr_addr = ba[0]; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            start = 1'b0; num = 4'h5; key = 4'h3; wr_addr = 4'hF;
            wait_done(n);
            chk("b2b_spacing", 32'(n), 32'd5);
            chk("b2b_product", 32'(product), 32'(be[i]));
            if (i < 2) begin
                num = bn[i+1]; key = bk[i+1]; wr_addr = ba[i+1]; start = 1'b1;
                tick();
                chk("b2b_accept_busy", 32'(busy), 32'h1);
                chk("b2b_accept_done", 32'(done), 32'h0);
            end
        end
        start = 1'b0;
        rd_addr = 4'h3;
        tick();
        chk("b2b_read3", 32'(rd_data), 32'hC4);

        // Start pulses while busy are ignored; also overwrites addr 2
        num = 4'h8; key = 4'h8; wr_addr = 4'h2; start = 1'b1;
        tick();
        num = 4'hF; key = 4'hF; wr_addr = 4'h5;
        for (int i = 0; i < 4; i++) tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_product", 32'(product), 32'h10);
        rd_addr = 4'h2;
        tick();
        chk("overwrite_read2", 32'(rd_data), 32'h10);
        rd_addr = 4'h5;
        tick();
        chk("ign_read5", 32'(rd_data), 32'h0);

        // Write-first: rd_addr matches the destination during the write edge
        num = 4'hC; key = 4'hA; wr_addr = 4'h6; rd_addr = 4'h6; start = 1'b1;
        tick();
        start = 1'b0;
        chk("wf_before", 32'(rd_data), 32'h0);
        wait_done(n);
        chk("wf_latency", 32'(n), 32'd5);
        chk("wf_rd_data", 32'(rd_data), 32'h1E);

        // Reset in the second MULT cycle aborts the operation
        num = 4'h8; key = 4'h8; wr_addr = 4'h7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_product", 32'(product), 32'h0);
        resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        rd_addr = 4'h7;
        tick();
        chk("abort_read7", 32'(rd_data), 32'h0);
        rd_addr = 4'h8;
        tick();
        chk("abort_valid8_cleared", 32'(rd_data), 32'h0);
        rd_addr = 4'h3;
        tick();
        chk("abort_valid3_cleared", 32'(rd_data), 32'h0);

        // Zero operand still completes and writes
        num = 4'h0; key = 4'h5; wr_addr = 4'h9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("zero_latency", 32'(n), 32'd5);
        chk("zero_product", 32'(product), 32'h0);

        // Wide instance: WIDTH=8, ROT=3
        num8 = 8'hFF; key8 = 8'hFF; wa8 = 4'h0; ra8 = 4'h0; start8 = 1'b1;
        tick();
        start8 = 1'b0; num8 = 8'h00; key8 = 8'h00;
        wait_done8(n);
        chk("w8_latency", 32'(n), 32'd9);
        chk("w8_product", 32'(product8), 32'hFE01);
        chk("w8_busy", 32'(busy8), 32'h0);
        chk("w8_read0", 32'(rd_data8), 32'hFE01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rot_mul_store.md
ROT_MUL_STORE -- requirements
Module: rot_mul_store

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of result-memory entries (power of two, at least 2).
REQ-003 The block SHALL have parameter ROT, default 2, giving the right-rotate amount applied to num (legal range 0..WIDTH-1).
REQ-004 The block SHALL use AW = log2(DEPTH) as its address width.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: the reset, which is synchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: an operation request, sampled only while busy is 0.
REQ-008 The block SHALL have port num, input, WIDTH bits: the plaintext operand.
REQ-009 The block SHALL have port key, input, WIDTH bits: the multiplier operand.
REQ-010 The block SHALL have port wr_addr, input, AW bits: the destination memory entry for the result.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a result is written.
REQ-013 The block SHALL have port product, output, 2*WIDTH bits: the last result written, held until the next write.
REQ-014 The block SHALL have port rd_addr, input, AW bits: the read address.
REQ-015 The block SHALL have port rd_data, output, 2*WIDTH bits: registered read data.

Function
REQ-016 The block SHALL compute result = rotr(num, ROT) * key, unsigned, exact in 2*WIDTH bits with no truncation.
REQ-017 The block SHALL implement the state machine states IDLE, MULT and WRITE.
REQ-018 In IDLE with start=1 at edge E0, the block SHALL capture rotr(num,ROT), key and wr_addr, load count=WIDTH, clear the accumulator, set busy=1 and go to MULT.
REQ-019 In MULT, each edge SHALL perform one shift-add step: if the multiplier LSB is 1, add the multiplicand to the upper half with carry; then shift {carry, acc, multiplier} right 1; then decrement count.
REQ-020 The block SHALL move from MULT to WRITE after exactly WIDTH steps (edges E1..EWIDTH).
REQ-021 At edge E(WIDTH+1), in WRITE, the block SHALL write the result to mem[wr_addr], set valid[wr_addr]=1, update product, set done=1, set busy=0 and go to IDLE.
REQ-022 Latency SHALL be: done high in the cycle after edge E(WIDTH+1); maximum throughput SHALL be one operation every WIDTH+1 cycles.
REQ-023 A start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the in-flight operation.
REQ-024 A start asserted in the cycle in which done=1 SHALL be accepted, giving back-to-back operation.
REQ-025 Changes to num, key or wr_addr after E0 SHALL NOT affect the in-flight operation.
REQ-026 done SHALL be high for exactly one cycle per completed operation and SHALL never be high while busy=1.
REQ-027 A read SHALL be synchronous: rd_data at edge N+1 equals mem[rd_addr sampled at N] if valid, else 0.
REQ-028 A read and a write to the same address on the same edge SHALL return the newly written data (write-first).
REQ-029 key=0 or num=0 SHALL give result 0, and the result SHALL still be written with valid set.
REQ-030 Writing an address that already holds a result SHALL overwrite it.

Reset
REQ-031 When resetn=0 at an edge, the block SHALL force state=IDLE, busy=0, done=0, product=0, rd_data=0, clear all valid bits and the accumulator, and SHALL ignore start.
REQ-032 A reset asserted mid-operation SHALL abort the operation with no memory write and no done pulse.
REQ-033 Memory data bits SHALL NOT be reset; invalid entries SHALL read as 0.
REQ-034 The first start SHALL be accepted on the first edge after resetn returns to 1.

Verification
REQ-035 The bench SHALL cover the defaults case num=1000, key=1000, wr_addr=8: done occurs 5 cycles after the accepting edge, product=00010000, and a later read of addr 8 returns 00010000.
REQ-036 The bench SHALL cover back-to-back sequencing: (1001,1000) gives 0x30, then (1100,1010) gives 0x1E, then (1011,1110) gives 0xC4, with each start issued on the done cycle and done spaced exactly 5 cycles apart.
REQ-037 The bench SHALL cover start pulses during busy: these are ignored, exactly one done is produced, and product matches the first operands only.
REQ-038 The bench SHALL cover resetn=0 in the second MULT cycle: no done, addr unwritten (reads 0), busy=0 on the next cycle, and all valid bits cleared.
REQ-039 The bench SHALL cover WIDTH=8, ROT=3, num=0xFF, key=0xFF: product=0xFE01, with done WIDTH+1=9 edges after the accepting edge.
REQ-040 The bench SHALL cover rd_addr equal to wr_addr on the WRITE edge: rd_data shows the new result on the next cycle.
